im_loader: RTL
==============

# im_loader

Writable instruction memory with a byte-stream loader front end. An external source (debug link, boot ROM streamer) pushes program bytes over a valid/ready handshake. The block stores them in a byte-wide array and holds the core in reset until the load completes. The core reads 32-bit instructions through a combinational, byte-addressed, big-endian port: byte at `address` is bits [31:24].

## Interface
Parameters:
- `MEM_BYTES`, 32, instruction memory size in bytes; must be a power of two and at least 4.
- `LEN_W`, 16, width of the load-length field.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; `load_len` is sampled with it.
- `load_len`  in  LEN_W  number of bytes to load.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `address`  in  32  core fetch byte address.
- `instruction`  out  32  `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed successfully.
- `err`  out  1  last `start` was rejected.
- `cpu_hold`  out  1  core must be held in reset while this is 1.

## Operation
- States: IDLE, LOAD, DONE, ERROR.
- Reset, asynchronous:
  - State goes to IDLE and the write pointer `wr_ptr` is cleared to 0.
  - Outputs: `byte_ready`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1.
  - Memory contents are not cleared.
- `start` sampled in IDLE, DONE or ERROR:
  - Valid `load_len` means non-zero, ≤ MEM_BYTES, and a multiple of 4.
  - Valid: go to LOAD, `wr_ptr`=0, latch the length, clear `done` and `err`.
  - Invalid: go to ERROR. `err`=1, `done`=0, `cpu_hold`=1, memory untouched.
- `start` while in LOAD is ignored.
- LOAD:
  - `byte_ready`=1, `busy`=1, `cpu_hold`=1.
  - On `byte_valid && byte_ready`: `mem[wr_ptr] <= byte_data` and `wr_ptr` increments.
  - The handshake that writes byte index `len-1` moves the state to DONE.
  - `byte_valid` low stalls with no state change.
- DONE: `done`=1, `cpu_hold`=0, `busy`=0, `byte_ready`=0.
- ERROR: `err`=1, `cpu_hold`=1, `busy`=0, `byte_ready`=0. Only a valid `start` or `rst` leaves ERROR.
- Read port:
  - Each byte index is taken modulo MEM_BYTES, i.e. the low `log2(MEM_BYTES)` bits of `address+k`.
  - A word straddling the top of memory wraps to byte 0.
  - The output is purely combinational from `address` and the array.
- Bytes beyond `len` keep their previous contents.

## Timing
- `byte_ready`, `busy`, `done`, `err` and `cpu_hold` are decoded from registered state only, with no combinational path from inputs.
- `start` at edge N puts the block in LOAD after edge N. `byte_ready`=1 from then on.
- Throughput is one byte per cycle.
- With `byte_valid` held high, the final byte is accepted at edge N+len.
- `done`=1 and `cpu_hold`=0 in the cycle after that edge.
- A written byte is visible on `instruction` in the cycle after its accepting edge.
- Reset mid-LOAD aborts the load immediately:
  - Bytes already written remain in memory.
  - Outputs take their reset values asynchronously.
  - `cpu_hold` goes to 1 without waiting for a clock edge.
- `start` and `byte_valid` in the same cycle while in IDLE/DONE: `start` wins. No byte is written that cycle, because `byte_ready` was 0.

## Test plan
- **Reset:** assert `rst` mid-cycle -> `cpu_hold`=1 and `busy`=`done`=`err`=`byte_ready`=0 immediately, before any clock edge.
- **Full load:**
  - Stimulus: `start` with `load_len`=8, then stream 0x00,0x50,0x00,0x93,0x00,0xA0,0x01,0x13 back-to-back.
  - Required: `done`=1 exactly 9 cycles after `start`, `cpu_hold`=0.
  - Reads: `address`=0 -> 0x00500093, `address`=4 -> 0x00A00113.
- **Stalls:** same 8-byte load with `byte_valid` toggled 1,0,0,1,... -> only handshake cycles write; final memory is identical to the full-load case; `busy` stays 1 throughout.
- **Invalid lengths:** `start` with `load_len`=0, 6, and MEM_BYTES+4 -> `err`=1, `cpu_hold`=1, memory unchanged. A following `start` with `load_len`=4 clears `err`.
- **Wrap read:** after a full 32-byte load of bytes 0x00..0x1F, `address`=30 -> 0x1E1F0001 and `address`=32 -> 0x00010203.
- **Reset mid-load / start during LOAD:**
  - Pulse `start` again after byte 3 -> ignored; the load still completes at `len`.
  - Assert `rst` after byte 5 of an 8-byte load -> IDLE, `cpu_hold`=1; bytes 0..4 read back as written.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream loader handshake plus the core's instruction fetch port.
// master = stream source / core side, slave = the im_loader.
interface im_loader_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] address;
  logic [31:0] instruction;

  modport master (
    output byte_data, byte_valid, address,
    input  byte_ready, instruction
  );

  modport slave (
    input  byte_data, byte_valid, address,
    output byte_ready, instruction
  );
endinterface

// File: rtl/im_loader.sv
// Writable byte-wide instruction memory with a valid/ready byte loader.
// Holds the core in reset until a load completes; big-endian 32-bit read port.

// One byte lane of the read port: fetches mem[base+LANE] with wrap-around.
module im_loader_rd_lane #(
  parameter int MEM_BYTES = 32,
  parameter int AW        = 5,
  parameter int LANE      = 0
) (
  input  logic [MEM_BYTES-1:0][7:0] mem,
  input  logic [AW-1:0]             base,
  output logic [7:0]                q
);
  logic [AW-1:0] idx;

  assign idx = base + AW'(LANE);
  assign q   = mem[idx];
endmodule

module im_loader #(
  parameter int MEM_BYTES = 32,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  im_loader_if.slave       bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      we;
  logic                      len_ok;
  logic [MEM_BYTES-1:0][7:0] mem;
  logic [LANES-1:0][7:0]     lane_q;
  logic                      unused_addr;

  // Length must be a whole number of words that fits in the array.
  assign len_ok = (load_len != '0) &&
                  (load_len[1:0] == 2'b00) &&
                  ({1'b0, load_len} <= (LEN_W+1)'(MEM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    we       = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.byte_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + LEN_W'(1);
          if (wr_ptr_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      default: begin
        // A start outside LOAD always wins over a same-cycle byte:
        // byte_ready is low here, so nothing is written.
        if (start) begin
          if (len_ok) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            len_d    = load_len;
          end else begin
            state_d  = ERROR;
          end
        end
      end
    endcase
  end

  // Memory is deliberately left out of reset so an aborted load keeps its bytes.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= bus.byte_data;
  end

  // Status is decoded from the state register alone.
  assign bus.byte_ready = (state_q == LOAD);
  assign busy           = (state_q == LOAD);
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERROR);
  assign cpu_hold       = (state_q != DONE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    im_loader_rd_lane #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW),
      .LANE      (l)
    ) u_lane (
      .mem  (mem),
      .base (bus.address[AW-1:0]),
      .q    (lane_q[l])
    );
  end

  assign bus.instruction = {lane_q[0], lane_q[1], lane_q[2], lane_q[3]};
  assign unused_addr     = ^bus.address[31:AW];
endmodule
